// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one 8-bit ALU between two requesters
// Optional feature: define ALU_ARB_ZERO_FLAG_EN to add the registered rsp_zero flag.
module alu_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [2:0] req0_op,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [2:0] req1_op,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_result
`ifdef ALU_ARB_ZERO_FLAG_EN
    ,
    output logic       rsp_zero
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [7:0] a_q, a_d, b_q, b_d, result_q, result_d, alu;
    logic       id_q, id_d, last_q, last_d, gnt0, gnt1;
`ifdef ALU_ARB_ZERO_FLAG_EN
    logic       zero_q, zero_d;
    assign rsp_zero = zero_q;
`endif
    assign rsp_valid  = state_q == RESP;
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    // grant selection, operand capture, ALU evaluation and FSM sequencing
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        last_d     = last_q;
        result_d   = result_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
`ifdef ALU_ARB_ZERO_FLAG_EN
        zero_d     = zero_q;
`endif
        gnt1 = req1_valid && (!req0_valid || !last_q);
        gnt0 = req0_valid && !gnt1;
        alu  = op_q == 3'b000 ? a_q + b_q :
               op_q == 3'b001 ? a_q - b_q :
               op_q == 3'b010 ? a_q & b_q :
               op_q == 3'b011 ? a_q | b_q :
               op_q == 3'b100 ? ~a_q : 8'h00;
        case (state_q)
            IDLE: if (gnt0 || gnt1) begin
                req0_ready = gnt0 && rst_n;
                req1_ready = gnt1 && rst_n;
                op_d       = gnt1 ? req1_op : req0_op;
                a_d        = gnt1 ? req1_a : req0_a;
                b_d        = gnt1 ? req1_b : req0_b;
                id_d       = gnt1;
                last_d     = gnt1;
                state_d    = EXEC;
            end
            EXEC: begin
                result_d = alu;
`ifdef ALU_ARB_ZERO_FLAG_EN
                zero_d   = alu == 8'h00;
`endif
                state_d  = RESP;
            end
            RESP: state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    // state and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= 3'b000;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            id_q     <= 1'b0;
            last_q   <= 1'b1;
            result_q <= 8'h00;
`ifdef ALU_ARB_ZERO_FLAG_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            id_q     <= id_d;
            last_q   <= last_d;
            result_q <= result_d;
`ifdef ALU_ARB_ZERO_FLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a transaction-level reference model
module tb_alu_arbiter;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b1;
    logic [2:0] req0_op = 3'd0, req1_op = 3'd0;
    logic [7:0] req0_a = 8'h00, req0_b = 8'h00, req1_a = 8'h00, req1_b = 8'h00;
    logic       req0_ready, req1_ready, rsp_valid, rsp_id;
    logic [7:0] rsp_result;
`ifdef ALU_ARB_ZERO_FLAG_EN
    logic       rsp_zero;
`endif

    typedef struct { logic id; logic [7:0] res; } exp_t;
    exp_t sb[$];
    int   vectors = 0, miscompares = 0;
    int   cyc = 0, gcyc = 0;
    bit   busy = 0, last = 1;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result)
`ifdef ALU_ARB_ZERO_FLAG_EN
        , .rsp_zero(rsp_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [2:0] op, input int a, input int b);
        int r;
        case (op)
            3'd0: r = (a + b) % 256;
            3'd1: r = (a - b + 256) % 256;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = 255 - a;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    // reference model: predicts grants, response window and pushes expected results
    always @(negedge clk) begin
        bit w0, w1;
        exp_t e;
        cyc++;
        if (!rst_n) begin
            busy = 0;
            last = 1;
            chk("reset_ctrl", {13'd0, req0_ready, req1_ready, rsp_valid}, 16'd0);
            chk("reset_data", {7'd0, rsp_id, rsp_result}, 16'd0);
`ifdef ALU_ARB_ZERO_FLAG_EN
            chk("reset_zero", {15'd0, rsp_zero}, 16'd0);
`endif
        end else if (busy) begin
            chk("rsp_valid", {15'd0, rsp_valid}, {15'd0, cyc >= gcyc + 2});
            chk("ready_while_busy", {14'd0, req1_ready, req0_ready}, 16'd0);
            if (cyc >= gcyc + 2 && rsp_ready) busy = 0;
        end else begin
            w0 = 0;
            w1 = 0;
            if (req0_valid && req1_valid) begin
                if (last) w0 = 1; else w1 = 1;
            end else begin
                w0 = req0_valid;
                w1 = req1_valid;
            end
            chk("rsp_valid_idle", {15'd0, rsp_valid}, 16'd0);
            chk("grant", {14'd0, req1_ready, req0_ready}, {14'd0, w1, w0});
            if (w0 || w1) begin
                e.id  = w1;
                e.res = w1 ? model(req1_op, req1_a, req1_b) : model(req0_op, req0_a, req0_b);
                sb.push_back(e);
                busy = 1;
                gcyc = cyc;
                last = w1;
            end
        end
    end

    // monitor: compares every presented response cycle against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) chk("rsp_unexpected", 16'd1, 16'd0);
            else begin
                chk("rsp_id", {15'd0, rsp_id}, {15'd0, sb[0].id});
                chk("rsp_result", {8'd0, rsp_result}, {8'd0, sb[0].res});
`ifdef ALU_ARB_ZERO_FLAG_EN
                chk("rsp_zero", {15'd0, rsp_zero}, {15'd0, sb[0].res == 8'h00});
`endif
                if (rsp_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic step(input bit v0, input logic [2:0] o0, input logic [7:0] a0, input logic [7:0] b0,
                        input bit v1, input logic [2:0] o1, input logic [7:0] a1, input logic [7:0] b1, input bit rr);
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
        rsp_ready = rr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        step(1, 3'd0, 8'h0F, 8'h01, 0, 3'd0, 8'h00, 8'h00, 1);
        repeat (4) step(0, 3'd0, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h00, 1);
        do_reset();
        repeat (9) step(1, 3'd1, 8'h05, 8'h07, 1, 3'd3, 8'hF0, 8'h0F, 1);
        repeat (3) step(0, 3'd0, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h00, 1);
        step(0, 3'd0, 8'h00, 8'h00, 1, 3'd4, 8'hAA, 8'h00, 0);
        repeat (6) step(1, 3'd0, 8'h11, 8'h22, 1, 3'd0, 8'h33, 8'h44, 0);
        step(0, 3'd0, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h00, 1);
        repeat (6) step(0, 3'd0, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h00, 1);
        step(1, 3'd7, 8'h12, 8'h34, 0, 3'd0, 8'h00, 8'h00, 1);
        repeat (4) step(0, 3'd0, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h00, 1);
        step(1, 3'd2, 8'hFF, 8'h3C, 0, 3'd0, 8'h00, 8'h00, 1);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        do_reset();
        repeat (8) step(1, 3'd0, 8'hFF, 8'h01, 1, 3'd1, 8'h00, 8'h01, 1);
        repeat (600)
            step($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 3) != 0);
        repeat (6) step(0, 3'd0, 8'h00, 8'h00, 0, 3'd0, 8'h00, 8'h00, 1);
        chk("scoreboard_drained", sb.size(), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 req0_valid / req1_valid  input  1 each  requester n has an operation pending.
REQ-004 req0_ready / req1_ready  output  1 each  operation of requester n accepted this cycle.
REQ-005 req0_op / req1_op  input  3 each  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT, others illegal.
REQ-006 req0_a, req0_b / req1_a, req1_b  input  8 each  operands.
REQ-007 rsp_valid  output  1  response holding.
REQ-008 rsp_ready  input  1  consumer accepts response.
REQ-009 rsp_id  output  1  requester index owning response.
REQ-010 rsp_result  output  8  operation result.
REQ-011 rsp_zero  output  1  result equals 8'h00 (only with ALU_ARB_ZERO_FLAG_EN).

Function
REQ-012 The block SHALL share one 8-bit ALU datapath (opcodes per REQ-005) between two requesters via FSM states IDLE, EXEC, RESP.
REQ-013 IDLE: if any reqN_valid, grant one, capture op/a/b/id, assert reqN_ready for exactly that cycle, go EXEC; else stay IDLE.
REQ-014 reqN_ready SHALL be high only in IDLE and only for the granted requester; never both high.
REQ-015 Arbitration SHALL be round-robin: both valid -> grant the requester not granted last; one valid -> grant it regardless of history.
REQ-016 EXEC: compute result from captured operands into rsp_result, go RESP (one cycle).
REQ-017 RESP: rsp_valid=1, rsp_id/rsp_result stable; on rsp_ready=1 go IDLE and drop rsp_valid next cycle.
REQ-018 Latency: accept in cycle N -> rsp_valid first high in cycle N+2; minimum issue interval 3 cycles.
REQ-019 Arithmetic modulo 256: ADD a+b, SUB a-b (wraps, e.g. 00-01=FF), AND, OR, NOT=~a (b ignored); carry/borrow discarded.
REQ-020 Illegal opcode: accepted normally, rsp_result=8'h00.
REQ-021 reqN_valid changes while not granted SHALL have no effect; inputs sampled only at grant cycle.
REQ-022 Backpressure: rsp_ready low holds RESP indefinitely; no new grants meanwhile.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, rsp_valid=0, req0_ready=req1_ready=0, rsp_id=0, rsp_result=8'h00, rsp_zero=0, last-grant pointer=1 (req0 wins first tie).
REQ-024 Reset during EXEC or RESP SHALL discard the in-flight operation with no response issued.

Configuration
REQ-025 Macro ALU_ARB_ZERO_FLAG_EN defined: rsp_zero port present, registered with rsp_result, high iff rsp_result==8'h00; undefined: port absent, no flag logic.

Verification
REQ-026 Reset, then req0 valid ADD a=8'h0F b=8'h01, rsp_ready=1 -> req0_ready cycle N, rsp_valid cycle N+2, rsp_id=0, rsp_result=8'h10.
REQ-027 Both valid continuously, req0 SUB 05-07, req1 OR F0|0F -> grants alternate 0,1,0; results 8'hFE (id 0), 8'hFF (id 1).
REQ-028 req1 NOT a=8'hAA, rsp_ready held low 5 cycles -> rsp_valid/rsp_result=8'h55 stable 5 cycles, no readies asserted, released on rsp_ready.
REQ-029 req0 opcode 3'b111 a=8'h12 b=8'h34 -> rsp_result=8'h00; with macro, rsp_zero=1.
REQ-030 rst_n low during EXEC of req0 AND FF&3C -> rsp_valid stays 0; after release, both valid -> req0 granted first.
